// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared types for the register-file writeback controller.
// Entry layout and x0 helper used by the FIFO and the top.
package rv_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return rd == '0;
  endfunction
endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Writeback bus: ALU/LSU result handshakes, hazard query,
// register-file write port and bypass outputs.
interface rf_writeback_ctrl_if;
  import rv_wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;

  logic [REG_AW-1:0] chk_rs1;
  logic [REG_AW-1:0] chk_rs2;
  logic              hz_rs1;
  logic              hz_rs2;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  logic              fwd1_valid;
  logic              fwd2_valid;
  logic [XLEN-1:0]   fwd1_data;
  logic [XLEN-1:0]   fwd2_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready,
    input  hz_rs1, hz_rs2,
    input  rf_we, rf_rd, rf_wdata,
    input  fwd1_valid, fwd2_valid,
    input  fwd1_data, fwd2_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  chk_rs1, chk_rs2,
    output alu_ready, lsu_ready,
    output hz_rs1, hz_rs2,
    output rf_we, rf_rd, rf_wdata,
    output fwd1_valid, fwd2_valid,
    output fwd1_data, fwd2_data
  );
endinterface

// File: rtl/rf_writeback_ctrl_fifo.sv
// Circular buffer of long-latency results with per-slot
// valid bits so the top can compare pending destinations.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr            <= wr_ptr + 1'b1;
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        ent_valid[rd_ptr] <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload needs no reset: slot validity is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end
endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter: ALU priority, LSU FIFO, starvation guard.
// Define WB_BYPASS_EN to forward the output stage instead of flagging it.
module rf_writeback_ctrl
  import rv_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              reset,
  rf_writeback_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t                    lsu_entry;
  wb_entry_t                    head;
  logic                         fifo_empty;
  logic [CW-1:0]                fifo_count;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

  logic          fifo_ne;
  logic          hold;
  logic          alu_wr;
  logic          lsu_push;
  logic          pop;
  logic [SW-1:0] starve_cnt;
  logic          fifo_hit1;
  logic          fifo_hit2;
  logic          out_hit1;
  logic          out_hit2;

  assign fifo_ne       = !fifo_empty;
  assign hold          = fifo_ne && (starve_cnt == SW'(STARVE_MAX));
  assign bus.alu_ready = !hold;
  assign bus.lsu_ready = fifo_count < CW'(DEPTH);

  assign alu_wr   = bus.alu_valid && !hold && !is_x0(bus.alu_rd);
  assign lsu_push = bus.lsu_valid && bus.lsu_ready && !is_x0(bus.lsu_rd);
  assign pop      = fifo_ne && !alu_wr;

  assign lsu_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (lsu_push),
    .push_entry (lsu_entry),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!fifo_ne || pop) begin
      starve_cnt <= '0;
    end else if (alu_wr) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
    end else begin
      unique case (1'b1)
        alu_wr: begin
          bus.rf_we    <= 1'b1;
          bus.rf_rd    <= bus.alu_rd;
          bus.rf_wdata <= bus.alu_data;
        end
        pop: begin
          bus.rf_we    <= 1'b1;
          bus.rf_rd    <= head.rd;
          bus.rf_wdata <= head.data;
        end
        default: bus.rf_we <= 1'b0;
      endcase
    end
  end

  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == bus.chk_rs1) fifo_hit1 = 1'b1;
      if (ent_valid[i] && ent_rd[i] == bus.chk_rs2) fifo_hit2 = 1'b1;
    end
    if (is_x0(bus.chk_rs1)) fifo_hit1 = 1'b0;
    if (is_x0(bus.chk_rs2)) fifo_hit2 = 1'b0;
  end

  assign out_hit1 = bus.rf_we && bus.rf_rd == bus.chk_rs1
                    && !is_x0(bus.chk_rs1);
  assign out_hit2 = bus.rf_we && bus.rf_rd == bus.chk_rs2
                    && !is_x0(bus.chk_rs2);

`ifdef WB_BYPASS_EN
  assign bus.hz_rs1     = fifo_hit1;
  assign bus.hz_rs2     = fifo_hit2;
  assign bus.fwd1_valid = out_hit1;
  assign bus.fwd2_valid = out_hit2;
  assign bus.fwd1_data  = bus.rf_wdata;
  assign bus.fwd2_data  = bus.rf_wdata;
`else
  assign bus.hz_rs1     = fifo_hit1 || out_hit1;
  assign bus.hz_rs2     = fifo_hit2 || out_hit2;
  assign bus.fwd1_valid = 1'b0;
  assign bus.fwd2_valid = 1'b0;
  assign bus.fwd1_data  = '0;
  assign bus.fwd2_data  = '0;
`endif
endmodule
